// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the mips16 program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_seq_state_t;

  localparam int PC_W_DEF      = 13;
  localparam int RESET_VEC_DEF = 0;
  localparam int EXC_VEC_DEF   = 8;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
  import pc_seq_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] push_data_i,
  output logic [PC_W-1:0] top_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   w_top_idx;
  logic            w_pop;

  assign w_top_idx = r_ptr - PW'(1);
  assign empty_o   = (r_count == '0);
  assign full_o    = (r_count == CW'(RAS_DEPTH));
  assign top_o     = r_mem[w_top_idx];
  // A pop on an empty stack is a no-op; the caller falls back to its own target.
  assign w_pop     = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (w_pop && push_i) begin
      r_mem[w_top_idx] <= push_data_i;
    end else if (push_i) begin
      r_mem[r_ptr] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_pop && push_i) begin
      r_ptr   <= r_ptr;
      r_count <= r_count;
    end else if (push_i) begin
      r_ptr <= r_ptr + PW'(1);
      if (!full_o) r_count <= r_count + CW'(1);
    end else if (w_pop) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Fetch-PC sequencer: BOOT/RUN/HALT state machine, next-PC priority mux and PC register.
// Define PC_RAS_EN to add the return-address stack (pc_ras) for jal / jr $ra.
module pc_seq_unit
  import pc_seq_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int STEP      = 1,
  parameter int RESET_VEC = RESET_VEC_DEF,
  parameter int EXC_VEC   = EXC_VEC_DEF,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            halt_i,
  input  logic            resume_i,
  input  logic            br_valid_i,
  input  logic [PC_W-1:0] br_target_i,
  input  logic            jmp_valid_i,
  input  logic [PC_W-1:0] jmp_target_i,
  input  logic            call_i,
  input  logic            ret_i,
  input  logic            exc_i,
  output logic [PC_W-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            ras_empty_o,
  output logic            ras_full_o,
  output pc_seq_state_t   state_o
);

  localparam logic [PC_W-1:0] LP_RST = PC_W'(RESET_VEC);
  localparam logic [PC_W-1:0] LP_EXC = PC_W'(EXC_VEC);

  pc_seq_state_t   r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt, w_pc_inc, w_ret_tgt;

  assign w_pc_inc = r_pc + PC_W'(STEP);

`ifdef PC_RAS_EN
  logic            w_ras_push, w_ras_pop, w_ras_empty, w_ras_full;
  logic [PC_W-1:0] w_ras_top;

  assign w_ras_push = (r_state == RUN) && !exc_i && call_i && jmp_valid_i;
  assign w_ras_pop  = (r_state == RUN) && !exc_i && ret_i;

  pc_ras #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk        (clk),
    .rst        (rst),
    .push_i     (w_ras_push),
    .pop_i      (w_ras_pop),
    .push_data_i(w_pc_inc),
    .top_o      (w_ras_top),
    .empty_o    (w_ras_empty),
    .full_o     (w_ras_full)
  );

  assign w_ret_tgt   = w_ras_empty ? jmp_target_i : w_ras_top;
  assign ras_empty_o = w_ras_empty;
  assign ras_full_o  = w_ras_full;
`else
  logic w_unused;
  assign w_unused    = call_i;
  assign w_ret_tgt   = jmp_target_i;
  assign ras_empty_o = 1'b1;
  assign ras_full_o  = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
        w_pc_nxt    = LP_RST;
      end
      RUN: begin
        if (exc_i)            w_pc_nxt = LP_EXC;
        else if (ret_i)       w_pc_nxt = w_ret_tgt;
        else if (jmp_valid_i) w_pc_nxt = jmp_target_i;
        else if (br_valid_i)  w_pc_nxt = br_target_i;
        else if (halt_i)      w_state_nxt = HALT;
        else if (!stall_i)    w_pc_nxt = w_pc_inc;
      end
      HALT: begin
        if (exc_i) begin
          w_state_nxt = RUN;
          w_pc_nxt    = LP_EXC;
        end else if (resume_i) begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = BOOT;
        w_pc_nxt    = LP_RST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BOOT;
      r_pc    <= LP_RST;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Handshake: pc_valid_o qualifies pc_o each cycle; there is no ready, the fetch
  // stage consumes every valid PC, and back-pressure arrives only via stall_i/halt_i.
  assign pc_o       = r_pc;
  assign pc_valid_o = (r_state == RUN);
  assign state_o    = r_state;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed table-driven bench for pc_seq_unit; RAS sequences are built when PC_RAS_EN is defined.
module tb_pc_seq_unit;
  import pc_seq_pkg::*;

  localparam logic [7:0] C_STL = 8'h01, C_HLT = 8'h02, C_RES = 8'h04, C_BR = 8'h08;
  localparam logic [7:0] C_JMP = 8'h10, C_CAL = 8'h20, C_RET = 8'h40, C_EXC = 8'h80;

  typedef struct {
    string         nm;
    logic [7:0]    ctl;
    logic [12:0]   br_t;
    logic [12:0]   jmp_t;
    logic [12:0]   exp_pc;
    logic          exp_v;
    pc_seq_state_t exp_st;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, stall_i, halt_i, resume_i, br_valid_i, jmp_valid_i, call_i, ret_i, exc_i;
  logic [12:0]   br_target_i, jmp_target_i, pc_o;
  logic          pc_valid_o, ras_empty_o, ras_full_o;
  pc_seq_state_t state_o;

  int n_vec  = 0;
  int n_miss = 0;
  vec_t tbl [27];

  always #5 clk = ~clk;

  pc_seq_unit dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .halt_i(halt_i), .resume_i(resume_i),
    .br_valid_i(br_valid_i), .br_target_i(br_target_i),
    .jmp_valid_i(jmp_valid_i), .jmp_target_i(jmp_target_i),
    .call_i(call_i), .ret_i(ret_i), .exc_i(exc_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o),
    .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o), .state_o(state_o)
  );

  function automatic vec_t mk(string nm, logic [7:0] ctl, logic [12:0] br_t, logic [12:0] jmp_t,
                              logic [12:0] exp_pc, logic exp_v, pc_seq_state_t exp_st);
    vec_t v;
    v.nm = nm; v.ctl = ctl; v.br_t = br_t; v.jmp_t = jmp_t;
    v.exp_pc = exp_pc; v.exp_v = exp_v; v.exp_st = exp_st;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic [7:0] ctl, logic [12:0] br_t, logic [12:0] jmp_t);
    stall_i = ctl[0]; halt_i = ctl[1]; resume_i = ctl[2]; br_valid_i = ctl[3];
    jmp_valid_i = ctl[4]; call_i = ctl[5]; ret_i = ctl[6]; exc_i = ctl[7];
    br_target_i = br_t; jmp_target_i = jmp_t;
  endtask

  task automatic apply(vec_t v);
    drive(v.ctl, v.br_t, v.jmp_t);
    @(posedge clk);
    #1;
    chk({v.nm, " pc"}, 32'(pc_o), 32'(v.exp_pc));
    chk({v.nm, " valid"}, 32'(pc_valid_o), 32'(v.exp_v));
    chk({v.nm, " state"}, 32'(state_o), 32'(v.exp_st));
  endtask

  task automatic chk_ras(string nm, logic exp_empty, logic exp_full);
    chk({nm, " ras_empty"}, 32'(ras_empty_o), 32'(exp_empty));
    chk({nm, " ras_full"}, 32'(ras_full_o), 32'(exp_full));
  endtask

  initial begin
    tbl[0]  = mk("boot_to_run",   8'h00,         13'h0,  13'h0,    13'h0000, 1'b1, RUN);
    tbl[1]  = mk("inc1",          8'h00,         13'h0,  13'h0,    13'h0001, 1'b1, RUN);
    tbl[2]  = mk("inc2",          8'h00,         13'h0,  13'h0,    13'h0002, 1'b1, RUN);
    tbl[3]  = mk("inc3",          8'h00,         13'h0,  13'h0,    13'h0003, 1'b1, RUN);
    tbl[4]  = mk("inc4",          8'h00,         13'h0,  13'h0,    13'h0004, 1'b1, RUN);
    tbl[5]  = mk("inc5",          8'h00,         13'h0,  13'h0,    13'h0005, 1'b1, RUN);
    tbl[6]  = mk("stall1",        C_STL,         13'h0,  13'h0,    13'h0005, 1'b1, RUN);
    tbl[7]  = mk("stall2",        C_STL,         13'h0,  13'h0,    13'h0005, 1'b1, RUN);
    tbl[8]  = mk("stall3",        C_STL,         13'h0,  13'h0,    13'h0005, 1'b1, RUN);
    tbl[9]  = mk("stall_br",      C_STL | C_BR,  13'h40, 13'h0,    13'h0040, 1'b1, RUN);
    tbl[10] = mk("exc_jmp_br",    C_EXC | C_JMP | C_BR, 13'h20, 13'h100, 13'h0008, 1'b1, RUN);
    tbl[11] = mk("jmp_1ffe",      C_JMP,         13'h0,  13'h1FFE, 13'h1FFE, 1'b1, RUN);
    tbl[12] = mk("inc_1fff",      8'h00,         13'h0,  13'h0,    13'h1FFF, 1'b1, RUN);
    tbl[13] = mk("wrap",          8'h00,         13'h0,  13'h0,    13'h0000, 1'b1, RUN);
    tbl[14] = mk("jmp_9",         C_JMP,         13'h0,  13'h9,    13'h0009, 1'b1, RUN);
    tbl[15] = mk("halt",          C_HLT,         13'h0,  13'h0,    13'h0009, 1'b0, HALT);
    tbl[16] = mk("halt_hold",     8'h00,         13'h0,  13'h0,    13'h0009, 1'b0, HALT);
    tbl[17] = mk("halt_ign_br",   C_STL | C_BR | C_JMP, 13'h20, 13'h30, 13'h0009, 1'b0, HALT);
    tbl[18] = mk("resume",        C_RES,         13'h0,  13'h0,    13'h0009, 1'b1, RUN);
    tbl[19] = mk("after_resume",  8'h00,         13'h0,  13'h0,    13'h000A, 1'b1, RUN);
    tbl[20] = mk("br_over_halt",  C_HLT | C_BR,  13'h50, 13'h0,    13'h0050, 1'b1, RUN);
    tbl[21] = mk("inc_51",        8'h00,         13'h0,  13'h0,    13'h0051, 1'b1, RUN);
    tbl[22] = mk("halt2",         C_HLT | C_STL, 13'h0,  13'h0,    13'h0051, 1'b0, HALT);
    tbl[23] = mk("exc_in_halt",   C_EXC,         13'h0,  13'h0,    13'h0008, 1'b1, RUN);
    tbl[24] = mk("ret_empty",     C_RET,         13'h0,  13'h33,   13'h0033, 1'b1, RUN);
    tbl[25] = mk("jmp_over_br",   C_JMP | C_BR,  13'h70, 13'h60,   13'h0060, 1'b1, RUN);
    tbl[26] = mk("ret_over_jmp",  C_RET | C_JMP | C_BR, 13'h70, 13'h44, 13'h0044, 1'b1, RUN);

    drive(8'h00, 13'h0, 13'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset pc", 32'(pc_o), 32'h0);
    chk("reset valid", 32'(pc_valid_o), 32'h0);
    chk("reset state", 32'(state_o), 32'(BOOT));
    chk_ras("reset", 1'b1, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) apply(tbl[i]);

`ifdef PC_RAS_EN
    apply(mk("j_10",      C_JMP,         13'h0, 13'h10,  13'h010, 1'b1, RUN));
    apply(mk("jal_80",    C_JMP | C_CAL, 13'h0, 13'h80,  13'h080, 1'b1, RUN));
    chk_ras("one_entry", 1'b0, 1'b0);
    apply(mk("inc_81",    8'h00,         13'h0, 13'h0,   13'h081, 1'b1, RUN));
    apply(mk("inc_82",    8'h00,         13'h0, 13'h0,   13'h082, 1'b1, RUN));
    apply(mk("jal_c0",    C_JMP | C_CAL, 13'h0, 13'hC0,  13'h0C0, 1'b1, RUN));
    apply(mk("ret_83",    C_RET,         13'h0, 13'h1,   13'h083, 1'b1, RUN));
    apply(mk("ret_11",    C_RET,         13'h0, 13'h1,   13'h011, 1'b1, RUN));
    chk_ras("drained", 1'b1, 1'b0);

    apply(mk("j_100",     C_JMP,         13'h0, 13'h100, 13'h100, 1'b1, RUN));
    apply(mk("push1",     C_JMP | C_CAL, 13'h0, 13'h200, 13'h200, 1'b1, RUN));
    apply(mk("push2",     C_JMP | C_CAL, 13'h0, 13'h300, 13'h300, 1'b1, RUN));
    apply(mk("push3",     C_JMP | C_CAL, 13'h0, 13'h400, 13'h400, 1'b1, RUN));
    chk_ras("three", 1'b0, 1'b0);
    apply(mk("push4",     C_JMP | C_CAL, 13'h0, 13'h500, 13'h500, 1'b1, RUN));
    chk_ras("four", 1'b0, 1'b1);
    apply(mk("push5",     C_JMP | C_CAL, 13'h0, 13'h600, 13'h600, 1'b1, RUN));
    chk_ras("five", 1'b0, 1'b1);
    apply(mk("pop_501",   C_RET,         13'h0, 13'h1,   13'h501, 1'b1, RUN));
    chk_ras("after_pop", 1'b0, 1'b0);
    apply(mk("pop_401",   C_RET,         13'h0, 13'h1,   13'h401, 1'b1, RUN));
    apply(mk("pop_301",   C_RET,         13'h0, 13'h1,   13'h301, 1'b1, RUN));
    apply(mk("pop_201",   C_RET,         13'h0, 13'h1,   13'h201, 1'b1, RUN));
    chk_ras("oldest_lost", 1'b1, 1'b0);
    apply(mk("pop_under", C_RET,         13'h0, 13'h77,  13'h077, 1'b1, RUN));

    apply(mk("jal_90",    C_JMP | C_CAL, 13'h0, 13'h90,  13'h090, 1'b1, RUN));
    apply(mk("pop_push",  C_JMP | C_CAL | C_RET, 13'h0, 13'hA0, 13'h078, 1'b1, RUN));
    chk_ras("pop_push", 1'b0, 1'b0);
    apply(mk("pop_91",    C_RET,         13'h0, 13'h1,   13'h091, 1'b1, RUN));
    chk_ras("pop_91", 1'b1, 1'b0);
    apply(mk("exc_call",  C_EXC | C_JMP | C_CAL, 13'h0, 13'h300, 13'h008, 1'b1, RUN));
    chk_ras("exc_no_push", 1'b1, 1'b0);

    apply(mk("jal_20",    C_JMP | C_CAL, 13'h0, 13'h20,  13'h020, 1'b1, RUN));
    apply(mk("jal_30",    C_JMP | C_CAL, 13'h0, 13'h30,  13'h030, 1'b1, RUN));
    chk_ras("two_entries", 1'b0, 1'b0);
`endif

    apply(mk("halt3",     C_HLT,         13'h0, 13'h0,   13'h030 & {13{1'b0}} | pc_o, 1'b0, HALT));
    drive(C_JMP | C_EXC, 13'h0, 13'h55);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_halt pc", 32'(pc_o), 32'h0);
    chk("rst_halt valid", 32'(pc_valid_o), 32'h0);
    chk("rst_halt state", 32'(state_o), 32'(BOOT));
    chk_ras("rst_halt", 1'b1, 1'b0);
    apply(mk("reboot",    C_JMP | C_EXC, 13'h0, 13'h55, 13'h000, 1'b1, RUN));
    apply(mk("ret_33",    C_RET,         13'h0, 13'h33,  13'h033, 1'b1, RUN));
    apply(mk("inc_34",    8'h00,         13'h0, 13'h0,   13'h034, 1'b1, RUN));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
